// File: rtl/edgcol_hb_sequencer.sv
// Edge-collision hardware-block sequencer: walks the loaded edge slots, issues one
// compare per slot to the pipelined collision unit and ORs the returned hits.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, waiting for start
// ISSUE  | presenting compare requests for slots 0..N-1
// DRAIN  | requests finished, waiting for outstanding results
// DONE   | done=1, collision valid, waiting for the next start
module edgcol_hb_sequencer #(
    parameter int NUM_EDGES  = 16,
    parameter int IDX_WIDTH  = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IDX_WIDTH:0]   edgeCount,
    output logic                 done,
    output logic                 collision,
    output logic                 busy,
    output logic [IDX_WIDTH-1:0] edgeAddr,
    output logic                 cmpValid,
    input  logic                 cmpReady,
    input  logic                 cmpResultValid,
    input  logic                 cmpHit
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    localparam logic [IDX_WIDTH:0]   MAX_N   = (IDX_WIDTH+1)'(NUM_EDGES);
    localparam logic [IDX_WIDTH:0]   CNT_ONE = (IDX_WIDTH+1)'(1);
    localparam logic [IDX_WIDTH-1:0] IDX_ONE = IDX_WIDTH'(1);

    state_t               r_state, w_state_nxt;
    logic [IDX_WIDTH:0]   r_num;
    logic [IDX_WIDTH:0]   r_out, w_out_nxt;
    logic [IDX_WIDTH-1:0] r_idx;
    logic                 r_done, r_coll;

    logic [IDX_WIDTH:0]   w_clamped;
    logic                 w_start_ok, w_busy, w_issue, w_acc, w_res, w_last, w_stop_hit;

    assign w_clamped  = (edgeCount > MAX_N) ? MAX_N : edgeCount;
    assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_busy     = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    // Early exit keys off the registered flag, so requests stop the cycle after a hit returns.
    assign w_stop_hit = (EARLY_EXIT != 0) && r_coll;
    assign w_issue    = (r_state == S_ISSUE) && !w_stop_hit;
    assign w_acc      = w_issue && cmpReady;
    // A result with nothing outstanding is stray and must not underflow the counter.
    assign w_res      = cmpResultValid && w_busy && (r_out != '0);
    assign w_last     = ({1'b0, r_idx} == (r_num - CNT_ONE));

    always_comb begin
        w_out_nxt = r_out;
        if (w_acc && !w_res) begin
            w_out_nxt = r_out + CNT_ONE;
        end else if (!w_acc && w_res) begin
            w_out_nxt = r_out - CNT_ONE;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    w_state_nxt = (w_clamped == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if ((w_acc && w_last) || w_stop_hit) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_out_nxt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_num   <= '0;
            r_out   <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_coll  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_num  <= w_clamped;
                r_out  <= '0;
                r_idx  <= '0;
                r_coll <= 1'b0;
                r_done <= 1'b0;
            end else begin
                r_out <= w_out_nxt;
                if (w_acc && !w_last) begin
                    r_idx <= r_idx + IDX_ONE;
                end
                if (w_res) begin
                    r_coll <= r_coll | cmpHit;
                end
                if (w_state_nxt == S_DONE) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done      = r_done;
    assign collision = r_coll;
    assign busy      = w_busy;
    assign edgeAddr  = r_idx;
    assign cmpValid  = w_issue;

endmodule

// File: tb/tb_edgcol_hb_sequencer.sv
// Bench for edgcol_hb_sequencer: a latency-L collision-unit model answers requests,
// and a scoreboard queue holds the slot addresses each run is expected to issue.
module tb_edgcol_hb_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] edgeCount;
    logic       done, collision, busy, cmpValid;
    logic [3:0] edgeAddr;
    logic       cmpReady, cmpResultValid, cmpHit;

    int n_checks = 0;
    int n_err    = 0;
    int exp_addr_q[$];

    edgcol_hb_sequencer #(.NUM_EDGES(16), .IDX_WIDTH(4), .EARLY_EXIT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .edgeCount(edgeCount),
        .done(done), .collision(collision), .busy(busy), .edgeAddr(edgeAddr),
        .cmpValid(cmpValid), .cmpReady(cmpReady),
        .cmpResultValid(cmpResultValid), .cmpHit(cmpHit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One ECOL run; cycle 0 is the cycle in which start is driven.
    task automatic run_case(input string tag, input int ec, input int lat, input logic [15:0] hitm,
                            input int stall_lo, input int stall_hi, input int start_mid,
                            input int exp_reqs, input int exp_done, input logic exp_coll);
        bit res_v[80];
        bit res_h[80];
        bit seen_done = 0;
        int busy_end  = (ec == 0) ? 0 : exp_done - 1;
        int a;
        for (int i = 0; i < 80; i++) begin
            res_v[i] = 0;
            res_h[i] = 0;
        end
        for (int i = 0; i < exp_reqs; i++) exp_addr_q.push_back(i);
        for (int c = 0; c < 70; c++) begin
            if (c == 1) check({tag, "_done_clr"}, 32'(done), 0);
            if (c > 0 && !seen_done && done) begin
                seen_done = 1;
                check({tag, "_done_cycle"}, c, exp_done);
            end
            if (c > 0) check({tag, "_busy"}, 32'(busy), 32'((c >= 1 && c <= busy_end) ? 1 : 0));
            start          = (c == 0) || (c == start_mid);
            edgeCount      = 5'(ec);
            cmpReady       = !(c >= stall_lo && c <= stall_hi);
            cmpResultValid = res_v[c];
            cmpHit         = res_h[c];
            #1;
            if (cmpValid && cmpReady) begin
                a = int'(edgeAddr);
                if (exp_addr_q.size() == 0) begin
                    check({tag, "_extra_req"}, a, 32'hFFFF);
                end else begin
                    check({tag, "_addr"}, a, exp_addr_q.pop_front());
                end
                if (c + lat < 80) begin
                    res_v[c+lat] = 1;
                    res_h[c+lat] = hitm[a];
                end
            end
            if (seen_done && c >= exp_done + 1) break;
            next_cycle();
        end
        start          = 0;
        cmpResultValid = 0;
        cmpHit         = 0;
        if (!seen_done) check({tag, "_done_timeout"}, 0, 1);
        check({tag, "_done_hold"}, 32'(done), 1);
        check({tag, "_collision"}, 32'(collision), 32'(exp_coll));
        check({tag, "_missing_reqs"}, exp_addr_q.size(), 0);
        exp_addr_q.delete();
        next_cycle();
    endtask

    initial begin
        rst = 1; start = 0; edgeCount = 0;
        cmpReady = 1; cmpResultValid = 0; cmpHit = 0;
        repeat (3) next_cycle();
        check("rst_done", 32'(done), 0);
        check("rst_coll", 32'(collision), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(cmpValid), 0);
        check("rst_addr", 32'(edgeAddr), 0);
        rst = 0;
        next_cycle();

        run_case("n4_nohit", 4, 2, 16'h0000, -1, -1, -1, 4, 7, 1'b0);
        run_case("n0", 0, 2, 16'h0000, -1, -1, -1, 0, 2, 1'b0);
        run_case("early_exit", 8, 2, 16'h0002, -1, -1, -1, 4, 7, 1'b1);
        run_case("stall", 3, 2, 16'h0000, 2, 3, -1, 3, 8, 1'b0);
        run_case("clamp20", 20, 2, 16'h0000, -1, -1, 5, 16, 19, 1'b0);
        run_case("hit_last", 4, 2, 16'h0008, -1, -1, -1, 4, 7, 1'b1);
        run_case("lat3_hit", 5, 3, 16'h0010, -1, -1, -1, 5, 9, 1'b1);

        // Abort an N=8 run with reset, then feed stray results into IDLE.
        for (int c = 0; c < 7; c++) begin
            start          = (c == 0);
            edgeCount      = 5'd8;
            rst            = (c == 3);
            cmpReady       = 1;
            cmpResultValid = (c == 4 || c == 5);
            cmpHit         = (c == 4 || c == 5);
            if (c == 2) check("abort_busy_pre", 32'(busy), 1);
            if (c >= 4) begin
                check("abort_done", 32'(done), 0);
                check("abort_coll", 32'(collision), 0);
                check("abort_busy", 32'(busy), 0);
                check("abort_valid", 32'(cmpValid), 0);
                check("abort_addr", 32'(edgeAddr), 0);
            end
            next_cycle();
        end
        rst = 0; start = 0; cmpResultValid = 0; cmpHit = 0;

        run_case("after_abort", 4, 2, 16'h0000, -1, -1, -1, 4, 7, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
